// File: rtl/ysyx_24120009_lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit controller: data width,
// funct3 memory-op encodings and the controller state encodings.
package ysyx_24120009_lsu_ctrl_pkg;

   localparam int LSU_DATA_WIDTH = 32;

   localparam logic [2:0] MEM_B  = 3'b000;
   localparam logic [2:0] MEM_H  = 3'b001;
   localparam logic [2:0] MEM_W  = 3'b010;
   localparam logic [2:0] MEM_BU = 3'b100;
   localparam logic [2:0] MEM_HU = 3'b101;

   localparam logic [1:0] LSU_IDLE  = 2'd0;
   localparam logic [1:0] LSU_ISSUE = 2'd1;
   localparam logic [1:0] LSU_WAIT  = 2'd2;
   localparam logic [1:0] LSU_RESP  = 2'd3;

endpackage

// File: rtl/ysyx_24120009_store_align.sv
// Combinational store shaping: moves store data onto its byte lanes, builds
// the byte strobes and flags misaligned or illegal operations.
module ysyx_24120009_store_align
   import ysyx_24120009_lsu_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = LSU_DATA_WIDTH,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic [1:0]            addr_off,
   input  logic [2:0]            control,
   input  logic                  wen,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] wdata_shifted,
   output logic [STRB_WIDTH-1:0] wstrb,
   output logic                  err
);

   logic [STRB_WIDTH-1:0] strb_base;
   logic                  illegal;
   logic                  misalign;

   // Unsigned variants only make sense for loads, so they are illegal as stores.
   always_comb begin
      strb_base = '0;
      illegal   = 1'b0;
      misalign  = 1'b0;
      case (control)
         MEM_B:  strb_base = STRB_WIDTH'(4'b0001);
         MEM_H:  begin
            strb_base = STRB_WIDTH'(4'b0011);
            misalign  = addr_off[0];
         end
         MEM_W:  begin
            strb_base = STRB_WIDTH'(4'b1111);
            misalign  = |addr_off;
         end
         MEM_BU: begin
            strb_base = STRB_WIDTH'(4'b0001);
            illegal   = wen;
         end
         MEM_HU: begin
            strb_base = STRB_WIDTH'(4'b0011);
            misalign  = addr_off[0];
            illegal   = wen;
         end
         default: illegal = 1'b1;
      endcase
   end

   assign err           = illegal | misalign;
   assign wstrb         = (wen && !err) ? (strb_base << addr_off) : '0;
   assign wdata_shifted = wen ? (wdata << {addr_off, 3'b000}) : '0;

endmodule

// File: rtl/ysyx_24120009_lsu_ctrl.sv
// Load/store unit controller: accepts one memory op from EXU, runs the data
// memory request/response handshake and returns the raw word downstream.
module ysyx_24120009_lsu_ctrl
   import ysyx_24120009_lsu_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = LSU_DATA_WIDTH,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wen,
   input  logic [DATA_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [2:0]            req_control,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [DATA_WIDTH-1:0] mem_req_addr,
   output logic                  mem_req_wen,
   output logic [DATA_WIDTH-1:0] mem_req_wdata,
   output logic [STRB_WIDTH-1:0] mem_req_wstrb,
   input  logic                  mem_resp_valid,
   output logic                  mem_resp_ready,
   input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
   input  logic                  mem_resp_err,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [DATA_WIDTH-1:0] rsp_addr,
   output logic [2:0]            rsp_control,
   output logic                  rsp_wen,
   output logic                  rsp_err
);

   logic [1:0]            state;
   logic [DATA_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [STRB_WIDTH-1:0] wstrb_q;
   logic [2:0]            control_q;
   logic                  wen_q;
   logic                  err_q;

   logic [DATA_WIDTH-1:0] align_wdata;
   logic [STRB_WIDTH-1:0] align_wstrb;
   logic                  align_err;

   ysyx_24120009_store_align #(
      .DATA_WIDTH(DATA_WIDTH),
      .STRB_WIDTH(STRB_WIDTH)
   ) u_store_align (
      .addr_off     (req_addr[1:0]),
      .control      (req_control),
      .wen          (req_wen),
      .wdata        (req_wdata),
      .wdata_shifted(align_wdata),
      .wstrb        (align_wstrb),
      .err          (align_err)
   );

   // Rejected ops skip the bus entirely and go straight to the response beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= LSU_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         wstrb_q   <= '0;
         control_q <= '0;
         wen_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         case (state)
            LSU_IDLE: begin
               if (req_valid) begin
                  addr_q    <= req_addr;
                  wdata_q   <= align_wdata;
                  wstrb_q   <= align_wstrb;
                  control_q <= req_control;
                  wen_q     <= req_wen;
                  rdata_q   <= '0;
                  err_q     <= align_err;
                  state     <= align_err ? LSU_RESP : LSU_ISSUE;
               end
            end
            LSU_ISSUE: begin
               if (mem_req_ready) state <= LSU_WAIT;
            end
            LSU_WAIT: begin
               if (mem_resp_valid) begin
                  rdata_q <= wen_q ? '0 : mem_resp_rdata;
                  err_q   <= mem_resp_err;
                  state   <= LSU_RESP;
               end
            end
            LSU_RESP: begin
               if (rsp_ready) state <= LSU_IDLE;
            end
            default: state <= LSU_IDLE;
         endcase
      end
   end

   assign req_ready      = (state == LSU_IDLE);
   assign mem_req_valid  = (state == LSU_ISSUE);
   assign mem_resp_ready = (state == LSU_WAIT);
   assign rsp_valid      = (state == LSU_RESP);

   assign mem_req_addr  = {addr_q[DATA_WIDTH-1:2], 2'b00};
   assign mem_req_wen   = wen_q;
   assign mem_req_wdata = wdata_q;
   assign mem_req_wstrb = wstrb_q;

   assign rsp_rdata   = rdata_q;
   assign rsp_addr    = addr_q;
   assign rsp_control = control_q;
   assign rsp_wen     = wen_q;
   assign rsp_err     = err_q;

endmodule

// File: tb/tb_ysyx_24120009_lsu_ctrl.sv
// Self-checking bench for the LSU controller: directed vector table, corner
// sequences (reset in WAIT, back-to-back) and randomized ops vs a reference model.
module tb_ysyx_24120009_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_control;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_req_wen;
   logic [31:0] mem_req_wdata;
   logic [3:0]  mem_req_wstrb;
   logic        mem_resp_valid;
   logic        mem_resp_ready;
   logic [31:0] mem_resp_rdata;
   logic        mem_resp_err;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic [31:0] rsp_addr;
   logic [2:0]  rsp_control;
   logic        rsp_wen;
   logic        rsp_err;

   always #5 clk = ~clk;

   ysyx_24120009_lsu_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_wen       (req_wen),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .req_control   (req_control),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_addr  (mem_req_addr),
      .mem_req_wen   (mem_req_wen),
      .mem_req_wdata (mem_req_wdata),
      .mem_req_wstrb (mem_req_wstrb),
      .mem_resp_valid(mem_resp_valid),
      .mem_resp_ready(mem_resp_ready),
      .mem_resp_rdata(mem_resp_rdata),
      .mem_resp_err  (mem_resp_err),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_rdata     (rsp_rdata),
      .rsp_addr      (rsp_addr),
      .rsp_control   (rsp_control),
      .rsp_wen       (rsp_wen),
      .rsp_err       (rsp_err)
   );

   typedef struct {
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  ctrl;
      logic [31:0] memRdata;
      logic        memErr;
      logic [31:0] expWdata;
      logic [3:0]  expWstrb;
      logic        expAlignErr;
      logic [31:0] expRdata;
      logic        expRspErr;
      int          reqDelay;
      int          respDelay;
      int          rspDelay;
   } vec_t;

   int vectors = 0;
   int miscompares = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Expected results derived from access size and byte offset arithmetic.
   function automatic vec_t refModel(input vec_t v);
      vec_t r;
      int   off;
      int   bytes;
      bit   legal;
      r     = v;
      off   = int'(v.addr % 4);
      bytes = 1;
      legal = 1'b1;
      case (v.ctrl)
         3'd0: bytes = 1;
         3'd1: bytes = 2;
         3'd2: bytes = 4;
         3'd4: begin bytes = 1; legal = !v.wen; end
         3'd5: begin bytes = 2; legal = !v.wen; end
         default: legal = 1'b0;
      endcase
      r.expAlignErr = !legal || ((off % bytes) != 0);
      r.expWdata    = 32'(64'(v.wdata) << (8 * off));
      r.expWstrb    = (v.wen && !r.expAlignErr) ? 4'(((1 << bytes) - 1) << off) : 4'b0000;
      r.expRdata    = (r.expAlignErr || v.wen) ? 32'd0 : v.memRdata;
      r.expRspErr   = r.expAlignErr || v.memErr;
      return r;
   endfunction

   task automatic idleInputs();
      req_valid      = 1'b0;
      req_wen        = 1'b0;
      req_addr       = '0;
      req_wdata      = '0;
      req_control    = '0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = '0;
      mem_resp_err   = 1'b0;
      rsp_ready      = 1'b0;
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
   task automatic applyStimulus(input vec_t v);
      checkOutput("req_ready before op", 32'(req_ready), 32'd1);
      req_valid   = 1'b1;
      req_wen     = v.wen;
      req_addr    = v.addr;
      req_wdata   = v.wdata;
      req_control = v.ctrl;
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_wdata = $urandom;
      if (v.expAlignErr) begin
         checkOutput("err path mem_req_valid", 32'(mem_req_valid), 32'd0);
      end else begin
         for (int i = 0; i <= v.reqDelay; i++) begin
            checkOutput("mem_req_valid", 32'(mem_req_valid), 32'd1);
            checkOutput("mem_req_addr", mem_req_addr, v.addr & 32'hFFFF_FFFC);
            checkOutput("mem_req_wen", 32'(mem_req_wen), 32'(v.wen));
            checkOutput("mem_req_wstrb", 32'(mem_req_wstrb), 32'(v.expWstrb));
            if (v.wen) checkOutput("mem_req_wdata", mem_req_wdata, v.expWdata);
            checkOutput("req_ready in ISSUE", 32'(req_ready), 32'd0);
            checkOutput("rsp_valid in ISSUE", 32'(rsp_valid), 32'd0);
            if (i == v.reqDelay) mem_req_ready = 1'b1;
            @(negedge clk);
         end
         mem_req_ready = 1'b0;
         checkOutput("mem_req_valid after accept", 32'(mem_req_valid), 32'd0);
         for (int i = 0; i <= v.respDelay; i++) begin
            checkOutput("mem_resp_ready", 32'(mem_resp_ready), 32'd1);
            checkOutput("rsp_valid in WAIT", 32'(rsp_valid), 32'd0);
            if (i == v.respDelay) begin
               mem_resp_valid = 1'b1;
               mem_resp_rdata = v.memRdata;
               mem_resp_err   = v.memErr;
            end
            @(negedge clk);
         end
         mem_resp_valid = 1'b0;
         mem_resp_rdata = $urandom;
         mem_resp_err   = 1'b0;
      end
      for (int i = 0; i <= v.rspDelay; i++) begin
         checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
         checkOutput("rsp_rdata", rsp_rdata, v.expRdata);
         checkOutput("rsp_addr", rsp_addr, v.addr);
         checkOutput("rsp_control", 32'(rsp_control), 32'(v.ctrl));
         checkOutput("rsp_wen", 32'(rsp_wen), 32'(v.wen));
         checkOutput("rsp_err", 32'(rsp_err), 32'(v.expRspErr));
         checkOutput("req_ready in RESP", 32'(req_ready), 32'd0);
         checkOutput("mem_req_valid in RESP", 32'(mem_req_valid), 32'd0);
         checkOutput("mem_resp_ready in RESP", 32'(mem_resp_ready), 32'd0);
         if (i == v.rspDelay) rsp_ready = 1'b1;
         @(negedge clk);
      end
      rsp_ready = 1'b0;
      checkOutput("rsp_valid after transfer", 32'(rsp_valid), 32'd0);
      checkOutput("req_ready after transfer", 32'(req_ready), 32'd1);
   endtask

   task automatic checkAllIdle(input string tag);
      checkOutput({tag, " req_ready"}, 32'(req_ready), 32'd1);
      checkOutput({tag, " mem_req_valid"}, 32'(mem_req_valid), 32'd0);
      checkOutput({tag, " mem_resp_ready"}, 32'(mem_resp_ready), 32'd0);
      checkOutput({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
      checkOutput({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
      checkOutput({tag, " rsp_addr"}, rsp_addr, 32'd0);
      checkOutput({tag, " rsp_control"}, 32'(rsp_control), 32'd0);
      checkOutput({tag, " rsp_wen"}, 32'(rsp_wen), 32'd0);
      checkOutput({tag, " rsp_err"}, 32'(rsp_err), 32'd0);
      checkOutput({tag, " mem_req_wstrb"}, 32'(mem_req_wstrb), 32'd0);
   endtask

   vec_t tbl[11];
   vec_t v;

   initial begin
      //          wen addr          wdata         ctrl    memRdata      err expWdata      strb     aerr rdata         rerr rqD rsD rpD
      tbl[0]  = '{1'b1, 32'h80000003, 32'h000000AB, 3'b000, 32'h00000000, 1'b0, 32'hAB000000, 4'b1000, 1'b0, 32'h00000000, 1'b0, 0, 0, 0};
      tbl[1]  = '{1'b0, 32'h80000002, 32'h00000000, 3'b101, 32'hBEEF1234, 1'b0, 32'h00000000, 4'b0000, 1'b0, 32'hBEEF1234, 1'b0, 3, 1, 0};
      tbl[2]  = '{1'b0, 32'h80000001, 32'h00000000, 3'b010, 32'h00000000, 1'b0, 32'h00000000, 4'b0000, 1'b1, 32'h00000000, 1'b1, 0, 0, 0};
      tbl[3]  = '{1'b0, 32'h80000100, 32'h00000000, 3'b010, 32'hCAFEF00D, 1'b1, 32'h00000000, 4'b0000, 1'b0, 32'hCAFEF00D, 1'b1, 0, 0, 5};
      tbl[4]  = '{1'b1, 32'h80000012, 32'h00001234, 3'b001, 32'h00000000, 1'b0, 32'h12340000, 4'b1100, 1'b0, 32'h00000000, 1'b0, 1, 0, 0};
      tbl[5]  = '{1'b1, 32'h80000011, 32'h00001234, 3'b001, 32'h00000000, 1'b0, 32'h00000000, 4'b0000, 1'b1, 32'h00000000, 1'b1, 0, 0, 1};
      tbl[6]  = '{1'b1, 32'h80000000, 32'h000000FF, 3'b100, 32'h00000000, 1'b0, 32'h00000000, 4'b0000, 1'b1, 32'h00000000, 1'b1, 0, 0, 0};
      tbl[7]  = '{1'b0, 32'h80000000, 32'h00000000, 3'b011, 32'h00000000, 1'b0, 32'h00000000, 4'b0000, 1'b1, 32'h00000000, 1'b1, 0, 0, 0};
      tbl[8]  = '{1'b1, 32'h80000020, 32'hDEADBEEF, 3'b010, 32'h00000000, 1'b0, 32'hDEADBEEF, 4'b1111, 1'b0, 32'h00000000, 1'b0, 0, 2, 0};
      tbl[9]  = '{1'b0, 32'h80000005, 32'h00000000, 3'b000, 32'h11223344, 1'b0, 32'h00000000, 4'b0000, 1'b0, 32'h11223344, 1'b0, 0, 0, 0};
      tbl[10] = '{1'b1, 32'h80000006, 32'h0000005A, 3'b000, 32'h77777777, 1'b1, 32'h005A0000, 4'b0100, 1'b0, 32'h00000000, 1'b1, 0, 1, 0};

      idleInputs();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkAllIdle("reset");
      rst = 1'b0;
      @(negedge clk);

      foreach (tbl[i]) applyStimulus(tbl[i]);

      // Reset while waiting for the memory response; the late response must be ignored.
      req_valid   = 1'b1;
      req_wen     = 1'b0;
      req_addr    = 32'h80000040;
      req_control = 3'b010;
      @(negedge clk);
      req_valid     = 1'b0;
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      checkOutput("WAIT mem_resp_ready", 32'(mem_resp_ready), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst            = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_rdata = 32'h12345678;
      checkAllIdle("post-reset");
      @(negedge clk);
      checkOutput("late resp mem_resp_ready", 32'(mem_resp_ready), 32'd0);
      checkOutput("late resp rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("late resp mem_req_valid", 32'(mem_req_valid), 32'd0);
      mem_resp_valid = 1'b0;

      // Back-to-back word loads against a one-cycle memory.
      v = '{1'b0, 32'h80000100, 32'h0, 3'b010, 32'hA5A5A5A5, 1'b0, 32'h0, 4'b0, 1'b0, 32'hA5A5A5A5, 1'b0, 0, 0, 0};
      applyStimulus(v);
      v.addr     = 32'h80000104;
      v.memRdata = 32'h5A5A5A5A;
      v.expRdata = 32'h5A5A5A5A;
      applyStimulus(v);

      for (int n = 0; n < 300; n++) begin
         v.wen       = 1'($urandom_range(0, 1));
         v.addr      = $urandom;
         v.wdata     = $urandom;
         v.ctrl      = 3'($urandom_range(0, 7));
         v.memRdata  = $urandom;
         v.memErr    = ($urandom_range(0, 7) == 0);
         v.reqDelay  = int'($urandom_range(0, 3));
         v.respDelay = int'($urandom_range(0, 3));
         v.rspDelay  = int'($urandom_range(0, 3));
         applyStimulus(refModel(v));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
